// File: rtl/clint.sv
// Core-local interruptor: msip, 64-bit mtime with a prescaler, and mtimecmp on a
// single-beat 32-bit peripheral port; drives the msip/mtip levels to the trap controller.
module clint #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic        bus_rvalid,
  output logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic        software_interrupt,
  output logic        timer_interrupt
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [15:0] A_MSIP     = 16'h0000;
  localparam logic [15:0] A_MTCMP_LO = 16'h4000;
  localparam logic [15:0] A_MTCMP_HI = 16'h4004;
  localparam logic [15:0] A_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] A_MTIME_HI = 16'hBFFC;

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic          msip_q, msip_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          timer_q, timer_d;

  logic [15:0] addr_w;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, mapped;
  logic        wr, tick;
  logic [31:0] rd_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus_addr[1:0];

  always_comb begin
    addr_w      = {bus_addr[15:2], 2'b00};
    sel_msip    = (addr_w == A_MSIP);
    sel_cmp_lo  = (addr_w == A_MTCMP_LO);
    sel_cmp_hi  = (addr_w == A_MTCMP_HI);
    sel_time_lo = (addr_w == A_MTIME_LO);
    sel_time_hi = (addr_w == A_MTIME_HI);
    mapped      = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;
    wr          = bus_req & bus_we;
    tick        = (presc_q == PRESC_MAX);

    presc_d = tick ? '0 : presc_q + 1'b1;

    msip_d = msip_q;
    if (wr && sel_msip && bus_wstrb[0]) msip_d = bus_wdata[0];

    mtimecmp_d = mtimecmp_q;
    if (wr && sel_cmp_lo) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0],  bus_wdata, bus_wstrb);
    if (wr && sel_cmp_hi) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], bus_wdata, bus_wstrb);

    // A bus write to either half swallows the tick for the whole 64-bit counter.
    mtime_d = mtime_q;
    if (wr && (sel_time_lo || sel_time_hi)) begin
      if (sel_time_lo) mtime_d[31:0]  = merge(mtime_q[31:0],  bus_wdata, bus_wstrb);
      if (sel_time_hi) mtime_d[63:32] = merge(mtime_q[63:32], bus_wdata, bus_wstrb);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    rd_val = 32'd0;
    case (1'b1)
      sel_msip:    rd_val = {31'd0, msip_q};
      sel_cmp_lo:  rd_val = mtimecmp_q[31:0];
      sel_cmp_hi:  rd_val = mtimecmp_q[63:32];
      sel_time_lo: rd_val = mtime_q[31:0];
      sel_time_hi: rd_val = mtime_q[63:32];
      default:     rd_val = 32'd0;
    endcase

    rvalid_d = bus_req;
    rdata_d  = (bus_req && !bus_we) ? rd_val : 32'd0;
    err_d    = bus_req && !mapped;
    timer_d  = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      presc_q    <= '0;
      msip_q     <= 1'b0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      timer_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      msip_q     <= msip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
    end
  end

  assign bus_rvalid         = rvalid_q;
  assign bus_rdata          = rdata_q;
  assign bus_err            = err_q;
  assign software_interrupt = msip_q;
  assign timer_interrupt    = timer_q;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: one instance with TICK_DIV=4 (timer/compare behaviour)
// and one with TICK_DIV=1 (mtime carry, wrap and write-vs-tick behaviour).
module tb_clint;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b = 1'b1;

  logic        req4 = 0, we4 = 0;
  logic [15:0] addr4 = '0;
  logic [31:0] wdata4 = '0;
  logic [3:0]  strb4 = '0;
  logic        rvalid4, err4, sw4, timer4;
  logic [31:0] rdata4;

  logic        req1 = 0, we1 = 0;
  logic [15:0] addr1 = '0;
  logic [31:0] wdata1 = '0;
  logic [3:0]  strb1 = '0;
  logic        rvalid1, err1, sw1, timer1;
  logic [31:0] rdata1;

  clint #(.TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_b(rst_b), .bus_req(req4), .bus_we(we4), .bus_addr(addr4),
    .bus_wdata(wdata4), .bus_wstrb(strb4), .bus_rvalid(rvalid4), .bus_rdata(rdata4),
    .bus_err(err4), .software_interrupt(sw4), .timer_interrupt(timer4)
  );

  clint #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .bus_req(req1), .bus_we(we1), .bus_addr(addr1),
    .bus_wdata(wdata1), .bus_wstrb(strb1), .bus_rvalid(rvalid1), .bus_rdata(rdata1),
    .bus_err(err1), .software_interrupt(sw1), .timer_interrupt(timer1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int n_chk = 0;
  int n_fail = 0;
  int tcyc = 0;
  int cyc = 0;

  // cyc counts edges since reset release, so mtime of the TICK_DIV=4 instance is cyc/4
  always @(posedge clk) begin
    tcyc <= tcyc + 1;
    if (rst_b) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rvalid4 === 1'b1) begin
      if (q4.size() == 0) chk("rsp4_unexpected", 32'(rvalid4), 32'd0);
      else begin
        e = q4.pop_front();
        chk("rsp4_rdata", rdata4, e.rdata);
        chk("rsp4_err", 32'(err4), 32'(e.err));
        chk("rsp4_latency", 32'(tcyc), 32'(e.due));
      end
    end
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'(rvalid1), 32'd0);
      else begin
        e = q1.pop_front();
        chk("rsp1_rdata", rdata1, e.rdata);
        chk("rsp1_err", 32'(err1), 32'(e.err));
        chk("rsp1_latency", 32'(tcyc), 32'(e.due));
      end
    end
  end

  task automatic bus(input bit d1, input logic we, input logic [15:0] addr,
                     input logic [31:0] wd, input logic [3:0] strb,
                     input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.due   = tcyc + 1;
    if (d1) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; strb1 = strb;
      q1.push_back(e);
    end else begin
      req4 = 1'b1; we4 = we; addr4 = addr; wdata4 = wd; strb4 = strb;
      q4.push_back(e);
    end
    @(posedge clk); #1;
    req1 = 1'b0;
    req4 = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    @(posedge clk); #1;
    // request issued while still in reset must not produce a response
    req4 = 1'b1; we4 = 1'b0; addr4 = 16'h4004;
    @(posedge clk); #1;
    req4 = 1'b0;
    chk("rst_rvalid", 32'(rvalid4), 32'd0);
    chk("rst_rdata", rdata4, 32'd0);
    chk("rst_err", 32'(err4), 32'd0);
    chk("rst_sw4", 32'(sw4), 32'd0);
    chk("rst_timer4", 32'(timer4), 32'd0);
    chk("rst_sw1", 32'(sw1), 32'd0);
    chk("rst_timer1", 32'(timer1), 32'd0);
    rst_b = 1'b0;

    bus(0, 0, 16'h4004, 0, 0, 32'hFFFF_FFFF, 0);
    chk("post_rst_timer", 32'(timer4), 32'd0);

    bus(0, 1, 16'h0000, 32'd1, 4'hF, 0, 0);
    chk("sw_set", 32'(sw4), 32'd1);
    bus(0, 0, 16'h0000, 0, 0, 32'd1, 0);
    bus(0, 1, 16'h0000, 32'd0, 4'hF, 0, 0);
    chk("sw_clr", 32'(sw4), 32'd0);
    bus(0, 0, 16'h0000, 0, 0, 32'd0, 0);
    bus(0, 1, 16'h0000, 32'd1, 4'h0, 0, 0);
    chk("sw_nostrb", 32'(sw4), 32'd0);
    bus(0, 0, 16'h0003, 0, 0, 32'd0, 0);

    bus(0, 1, 16'h4004, 32'd0, 4'hF, 0, 0);
    bus(0, 1, 16'h4000, 32'd10, 4'hF, 0, 0);
    for (int i = 0; i < 100; i++) begin
      k = cyc;
      if (k / 4 > 11) break;
      bus(0, 0, 16'hBFF8, 0, 0, 32'(k / 4), 0);
      chk("timer_track", 32'(timer4), ((cyc - 1) / 4 >= 10) ? 32'd1 : 32'd0);
    end
    bus(0, 1, 16'h4000, 32'd100, 4'hF, 0, 0);
    chk("timer_hold", 32'(timer4), 32'd1);
    idle();
    chk("timer_fall", 32'(timer4), 32'd0);

    bus(0, 1, 16'h4000, 32'hAABB_CCDD, 4'b0101, 0, 0);
    bus(0, 0, 16'h4000, 0, 0, 32'h00BB_00DD, 0);

    bus(0, 0, 16'h1234, 0, 0, 32'd0, 1);
    bus(0, 1, 16'h1234, 32'hFFFF_FFFF, 4'hF, 0, 1);
    bus(0, 1, 16'h0004, 32'd1, 4'hF, 0, 1);
    bus(0, 0, 16'h0000, 0, 0, 32'd0, 0);
    bus(0, 0, 16'h4000, 0, 0, 32'h00BB_00DD, 0);
    bus(0, 0, 16'h4007, 0, 0, 32'd0, 0);
    chk("unmapped_sw", 32'(sw4), 32'd0);

    bus(1, 1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0);
    bus(1, 1, 16'hBFFC, 32'd0, 4'hF, 0, 0);
    idle();
    bus(1, 0, 16'hBFF8, 0, 0, 32'd0, 0);
    bus(1, 0, 16'hBFFC, 0, 0, 32'd1, 0);

    bus(1, 1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, 0);
    bus(1, 1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, 0);
    idle();
    bus(1, 0, 16'hBFF8, 0, 0, 32'd0, 0);
    bus(1, 0, 16'hBFFC, 0, 0, 32'd0, 0);

    bus(1, 1, 16'hBFF8, 32'd5, 4'hF, 0, 0);
    bus(1, 0, 16'hBFF8, 0, 0, 32'd5, 0);

    idle(); idle(); idle();
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
